// File: rtl/alu_acc_seq_if.sv
// Command channel of the accumulator sequencer: valid/ready handshake plus
// opcode, load select and operand/load data.
interface alu_acc_seq_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic         cmd_load;
    logic [W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_load,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_load,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/alu_acc_seq.sv
// Accumulator sequencer wrapped around a combinational ALU: IDLE -> ISSUE -> DONE.
// Optional macro ACC_STICKY_OVF_EN makes the overflow flag sticky until a load.
module alu_acc_seq #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_acc_seq_if.slave     cmd_if,
    output logic [W-1:0]     alu_a_o,
    output logic [W-1:0]     alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [W-1:0]     alu_y_i,
    input  logic             alu_carry_i,
    input  logic             alu_overflow_i,
    input  logic             alu_zero_i,
    output logic [W-1:0]     acc_o,
    output logic [2:0]       flags_o,
    output logic             res_valid_o,
    output logic [CNT_W-1:0] ops_done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       alu_a_q, alu_a_d;
    logic [W-1:0]       alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               load_q, load_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [2:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   ops_done_q, ops_done_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            load_q     <= 1'b0;
            acc_q      <= '0;
            flags_q    <= '0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            load_q     <= load_d;
            acc_q      <= acc_d;
            flags_q    <= flags_d;
            ops_done_q <= ops_done_d;
        end
    end

    // NOTE: every next-state signal is defaulted to its held value first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        load_d     = load_q;
        acc_d      = acc_q;
        flags_d    = flags_q;
        ops_done_d = ops_done_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    alu_a_d  = acc_q;
                    alu_b_d  = cmd_if.cmd_data;
                    alu_op_d = cmd_if.cmd_op;
                    load_d   = cmd_if.cmd_load;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (load_q) begin
                    acc_d   = alu_b_q;
                    flags_d = {1'b0, 1'b0, (alu_b_q == '0)};
                end else begin
                    acc_d = alu_y_i;
`ifdef ACC_STICKY_OVF_EN
                    flags_d = {alu_carry_i, flags_q[1] | alu_overflow_i, alu_zero_i};
`else
                    flags_d = {alu_carry_i, alu_overflow_i, alu_zero_i};
`endif
                end
                ops_done_d = ops_done_q + CNT_W'(1);
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake and strobe decode straight from the state, so reset forces them too.
    assign cmd_if.cmd_ready = (state_q == S_IDLE);
    assign res_valid_o      = (state_q == S_DONE);

    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_op_o   = alu_op_q;
    assign acc_o      = acc_q;
    assign flags_o    = flags_q;
    assign ops_done_o = ops_done_q;

endmodule
